// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: opcodes, special registers,
// status codes and the write-request record.
package wb_stage_pkg;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_SETX = 5'b10101;

    localparam logic [4:0] RSTATUS = 5'd30;
    localparam logic [4:0] RA      = 5'd31;

    localparam logic [31:0] STATUS_ALU  = 32'd1;
    localparam logic [31:0] STATUS_ADDI = 32'd2;
    localparam logic [31:0] STATUS_MULT = 32'd4;
    localparam logic [31:0] STATUS_DIV  = 32'd5;

    typedef enum logic {
        BUF_EMPTY,
        BUF_FULL
    } buf_state_t;

    typedef struct packed {
        logic        req;
        logic [4:0]  dest;
        logic [31:0] data;
    } wr_req_t;

endpackage

// File: rtl/wb_stage_decode.sv
// Combinational decode of the memory/writeback latch into a register-file
// write request, including the overflow-to-status rewrite.
module wb_decode
    import wb_stage_pkg::*;
(
    input  logic [4:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [31:0] data,
    input  logic [31:0] alu,
    input  logic [31:0] target,
    input  logic        overflow,
    output wr_req_t     req
);

    always_comb begin
        req = '0;
        unique case (opcode)
            OP_ALU: begin
                req.req  = 1'b1;
                req.dest = overflow ? RSTATUS : rd;
                req.data = overflow ? STATUS_ALU : alu;
            end
            OP_ADDI: begin
                req.req  = 1'b1;
                req.dest = overflow ? RSTATUS : rd;
                req.data = overflow ? STATUS_ADDI : alu;
            end
            OP_LW: begin
                req.req  = 1'b1;
                req.dest = rd;
                req.data = data;
            end
            OP_JAL: begin
                req.req  = 1'b1;
                req.dest = RA;
                req.data = target;
            end
            OP_SETX: begin
                req.req  = 1'b1;
                req.dest = RSTATUS;
                req.data = target;
            end
            default: req = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: pipeline writes take the register-file port unconditionally;
// multdiv results wait in a one-entry buffer and drain in idle cycles.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  mw_opcode,
    input  logic [4:0]  mw_rd,
    input  logic [31:0] mw_data,
    input  logic [31:0] mw_alu,
    input  logic [31:0] mw_target,
    input  logic        mw_overflow,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [31:0] md_result,
    input  logic [4:0]  md_rd,
    input  logic        md_exception,
    input  logic        md_is_div,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        pend_valid,
    output logic [4:0]  pend_rd
);

    wr_req_t    pipe_req;
    logic       pipe_we;
    logic       drain;
    logic       accept;
    logic [4:0] acc_rd;
    logic [31:0] acc_data;

    buf_state_t  state, state_next;
    logic [4:0]  buf_rd, buf_rd_next;
    logic [31:0] buf_data, buf_data_next;

    wb_decode u_decode (
        .opcode   (mw_opcode),
        .rd       (mw_rd),
        .data     (mw_data),
        .alu      (mw_alu),
        .target   (mw_target),
        .overflow (mw_overflow),
        .req      (pipe_req)
    );

    // A request to r0 is dropped, so it neither writes nor blocks the buffer.
    assign pipe_we = pipe_req.req && (pipe_req.dest != '0);

    always_comb begin
        drain    = (state == BUF_FULL) && !pipe_we;
        md_ready = (state == BUF_EMPTY) || drain;
        accept   = md_valid && md_ready;
        acc_rd   = md_exception ? RSTATUS : md_rd;
        acc_data = md_exception ? (md_is_div ? STATUS_DIV : STATUS_MULT) : md_result;

        state_next    = state;
        buf_rd_next   = buf_rd;
        buf_data_next = buf_data;
        if (drain) begin
            state_next    = BUF_EMPTY;
            buf_rd_next   = '0;
            buf_data_next = '0;
        end
        // Exceptions always target RSTATUS, so rd 0 here means a plain r0 result.
        if (accept && (acc_rd != '0)) begin
            state_next    = BUF_FULL;
            buf_rd_next   = acc_rd;
            buf_data_next = acc_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= BUF_EMPTY;
            buf_rd   <= '0;
            buf_data <= '0;
        end else begin
            state    <= state_next;
            buf_rd   <= buf_rd_next;
            buf_data <= buf_data_next;
        end
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (pipe_we) begin
            rf_we    = 1'b1;
            rf_waddr = pipe_req.dest;
            rf_wdata = pipe_req.data;
        end else if (drain) begin
            rf_we    = 1'b1;
            rf_waddr = buf_rd;
            rf_wdata = buf_data;
        end
        pend_valid = (state == BUF_FULL);
        pend_rd    = buf_rd;
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by randomized
// traffic compared against a queue-based reference model.
module tb_wb_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  mw_opcode;
    logic [4:0]  mw_rd;
    logic [31:0] mw_data;
    logic [31:0] mw_alu;
    logic [31:0] mw_target;
    logic        mw_overflow;
    logic        md_valid;
    logic        md_ready;
    logic [31:0] md_result;
    logic [4:0]  md_rd;
    logic        md_exception;
    logic        md_is_div;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pend_valid;
    logic [4:0]  pend_rd;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] IDLE_OP = 5'b00001;

    wb_stage dut (
        .clock        (clock),
        .reset        (reset),
        .mw_opcode    (mw_opcode),
        .mw_rd        (mw_rd),
        .mw_data      (mw_data),
        .mw_alu       (mw_alu),
        .mw_target    (mw_target),
        .mw_overflow  (mw_overflow),
        .md_valid     (md_valid),
        .md_ready     (md_ready),
        .md_result    (md_result),
        .md_rd        (md_rd),
        .md_exception (md_exception),
        .md_is_div    (md_is_div),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .pend_valid   (pend_valid),
        .pend_rd      (pend_rd)
    );

    always #5 clock = ~clock;

    task automatic pipe(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] d,
                        input logic [31:0] a, input logic [31:0] t, input logic ov);
        mw_opcode = op; mw_rd = rd; mw_data = d; mw_alu = a; mw_target = t; mw_overflow = ov;
    endtask

    task automatic md(input logic v, input logic [4:0] rd, input logic [31:0] r,
                      input logic exc, input logic dv);
        md_valid = v; md_rd = rd; md_result = r; md_exception = exc; md_is_div = dv;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pipe(5'b00000, 5'd0, '0, '0, '0, 1'b0);
        md(1'b0, '0, '0, 1'b0, 1'b0);
        #2;
        checks++;
        if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %b exp 0", rf_we); end
        checks++;
        if (pend_valid !== 1'b0 || pend_rd !== 5'd0)
            begin errors++; $display("FAIL reset_pend got %b/%0d exp 0/0", pend_valid, pend_rd); end
        checks++;
        if (md_ready !== 1'b1) begin errors++; $display("FAIL reset_md_ready got %b exp 1", md_ready); end
        @(negedge clock);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_pipeline();
        pipe(5'b00000, 5'd5, '0, 32'h10, '0, 1'b0); #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h10})
            begin errors++; $display("FAIL alu got %b/%0d/%h exp 1/5/10", rf_we, rf_waddr, rf_wdata); end
        pipe(5'b00000, 5'd5, '0, 32'h10, '0, 1'b1); #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd30, 32'd1})
            begin errors++; $display("FAIL alu_ovf got %b/%0d/%h exp 1/30/1", rf_we, rf_waddr, rf_wdata); end
        pipe(5'b00101, 5'd6, '0, 32'h77, '0, 1'b1); #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd30, 32'd2})
            begin errors++; $display("FAIL addi_ovf got %b/%0d/%h exp 1/30/2", rf_we, rf_waddr, rf_wdata); end
        pipe(5'b01000, 5'd9, 32'hCAFE_0001, 32'h5, '0, 1'b1); #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'hCAFE_0001})
            begin errors++; $display("FAIL lw got %b/%0d/%h exp 1/9/cafe0001", rf_we, rf_waddr, rf_wdata); end
        pipe(5'b00011, 5'd4, '0, '0, 32'h42, 1'b0); #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd31, 32'h42})
            begin errors++; $display("FAIL jal got %b/%0d/%h exp 1/31/42", rf_we, rf_waddr, rf_wdata); end
        pipe(5'b10101, 5'd4, '0, '0, 32'h99, 1'b0); #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd30, 32'h99})
            begin errors++; $display("FAIL setx got %b/%0d/%h exp 1/30/99", rf_we, rf_waddr, rf_wdata); end
        pipe(5'b00000, 5'd0, '0, 32'h10, '0, 1'b0); #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd0, 32'd0})
            begin errors++; $display("FAIL alu_r0 got %b/%0d/%h exp 0/0/0", rf_we, rf_waddr, rf_wdata); end
        pipe(5'b11111, 5'd3, 32'h1, 32'h2, 32'h3, 1'b0); #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd0, 32'd0})
            begin errors++; $display("FAIL other_op got %b/%0d/%h exp 0/0/0", rf_we, rf_waddr, rf_wdata); end
        pipe(IDLE_OP, '0, '0, '0, '0, 1'b0);
        tick();
    endtask

    task automatic test_buffer_accept();
        md(1'b1, 5'd7, 32'h1234, 1'b0, 1'b0); #1;
        checks++;
        if (md_ready !== 1'b1) begin errors++; $display("FAIL acc_ready got %b exp 1", md_ready); end
        tick();
        md(1'b0, '0, '0, 1'b0, 1'b0); #1;
        checks++;
        if (pend_valid !== 1'b1 || pend_rd !== 5'd7)
            begin errors++; $display("FAIL acc_pend got %b/%0d exp 1/7", pend_valid, pend_rd); end
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h1234})
            begin errors++; $display("FAIL acc_drain got %b/%0d/%h exp 1/7/1234", rf_we, rf_waddr, rf_wdata); end
        tick();
        checks++;
        if ({pend_valid, pend_rd, rf_we} !== {1'b0, 5'd0, 1'b0})
            begin errors++; $display("FAIL acc_empty got %b/%0d/%b exp 0/0/0", pend_valid, pend_rd, rf_we); end
    endtask

    task automatic test_back_to_back();
        md(1'b1, 5'd7, 32'hAAAA, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            pipe(5'b01000, 5'(9 + i), 32'h100 + 32'(i), '0, '0, 1'b0);
            md(1'b1, 5'd20, 32'hDEAD, 1'b0, 1'b0);
            #1;
            checks++;
            if (md_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 0", i, md_ready); end
            checks++;
            if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'(9 + i), 32'h100 + 32'(i)})
                begin errors++; $display("FAIL b2b_lw[%0d] got %b/%0d/%h", i, rf_we, rf_waddr, rf_wdata); end
            checks++;
            if (pend_valid !== 1'b1 || pend_rd !== 5'd7)
                begin errors++; $display("FAIL b2b_pend[%0d] got %b/%0d exp 1/7", i, pend_valid, pend_rd); end
            tick();
        end
        pipe(IDLE_OP, '0, '0, '0, '0, 1'b0);
        md(1'b1, 5'd12, 32'hBBBB, 1'b0, 1'b0); #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'hAAAA})
            begin errors++; $display("FAIL b2b_drain got %b/%0d/%h exp 1/7/aaaa", rf_we, rf_waddr, rf_wdata); end
        checks++;
        if (md_ready !== 1'b1) begin errors++; $display("FAIL b2b_drain_ready got %b exp 1", md_ready); end
        tick();
        md(1'b0, '0, '0, 1'b0, 1'b0); #1;
        checks++;
        if ({pend_valid, pend_rd, rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd12, 1'b1, 5'd12, 32'hBBBB})
            begin errors++; $display("FAIL b2b_second got %b/%0d/%b/%0d/%h exp 1/12/1/12/bbbb",
                                     pend_valid, pend_rd, rf_we, rf_waddr, rf_wdata); end
        tick();
    endtask

    task automatic test_exception();
        md(1'b1, 5'd3, 32'hFFFF_FFFF, 1'b1, 1'b1);
        tick();
        md(1'b1, 5'd4, 32'h1, 1'b1, 1'b0); #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd30, 32'd5})
            begin errors++; $display("FAIL exc_div got %b/%0d/%h exp 1/30/5", rf_we, rf_waddr, rf_wdata); end
        tick();
        md(1'b0, '0, '0, 1'b0, 1'b0); #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd30, 32'd4})
            begin errors++; $display("FAIL exc_mult got %b/%0d/%h exp 1/30/4", rf_we, rf_waddr, rf_wdata); end
        tick();
        md(1'b1, 5'd0, 32'h55, 1'b0, 1'b0);
        tick();
        md(1'b0, '0, '0, 1'b0, 1'b0); #1;
        checks++;
        if ({pend_valid, rf_we} !== 2'b00)
            begin errors++; $display("FAIL discard_r0 got %b/%b exp 0/0", pend_valid, rf_we); end
    endtask

    task automatic test_async_reset();
        pipe(5'b01000, 5'd8, 32'h1, '0, '0, 1'b0);
        md(1'b1, 5'd7, 32'h7777, 1'b0, 1'b0);
        tick();
        md(1'b0, '0, '0, 1'b0, 1'b0);
        #2;
        checks++;
        if (pend_valid !== 1'b1 || md_ready !== 1'b0)
            begin errors++; $display("FAIL ar_full got %b/%b exp 1/0", pend_valid, md_ready); end
        reset = 1'b0;
        pipe(5'b00000, 5'd0, '0, '0, '0, 1'b0);
        #1;
        checks++;
        if ({pend_valid, pend_rd, md_ready} !== {1'b0, 5'd0, 1'b1})
            begin errors++; $display("FAIL ar_immediate got %b/%0d/%b exp 0/0/1", pend_valid, pend_rd, md_ready); end
        @(negedge clock);
        reset = 1'b1;
        pipe(IDLE_OP, '0, '0, '0, '0, 1'b0);
        tick();
        checks++;
        if ({rf_we, pend_valid} !== 2'b00)
            begin errors++; $display("FAIL ar_stale got %b/%b exp 0/0", rf_we, pend_valid); end
    endtask

    task automatic test_random();
        logic [4:0]  q_rd[$];
        logic [31:0] q_data[$];
        logic [4:0]  ops[6] = '{5'b00000, 5'b00101, 5'b01000, 5'b00011, 5'b10101, 5'b00001};
        logic        p_req, p_we, e_drain, e_ready, e_we;
        logic [4:0]  p_dest, e_addr, n_rd;
        logic [31:0] p_data, e_data, n_data;
        for (int c = 0; c < 400; c++) begin
            pipe(($urandom_range(0, 9) < 6) ? ops[$urandom_range(0, 5)] : 5'($urandom),
                 5'($urandom), $urandom, $urandom, $urandom, ($urandom_range(0, 3) == 0));
            md(($urandom_range(0, 2) != 0), 5'($urandom), $urandom,
               ($urandom_range(0, 4) == 0), 1'($urandom));
            #1;
            p_req = 1'b1; p_dest = 5'd0; p_data = 32'd0;
            if (mw_opcode == 5'd0)       begin p_dest = mw_overflow ? 5'd30 : mw_rd; p_data = mw_overflow ? 32'd1 : mw_alu; end
            else if (mw_opcode == 5'd5)  begin p_dest = mw_overflow ? 5'd30 : mw_rd; p_data = mw_overflow ? 32'd2 : mw_alu; end
            else if (mw_opcode == 5'd8)  begin p_dest = mw_rd; p_data = mw_data; end
            else if (mw_opcode == 5'd3)  begin p_dest = 5'd31; p_data = mw_target; end
            else if (mw_opcode == 5'd21) begin p_dest = 5'd30; p_data = mw_target; end
            else p_req = 1'b0;
            p_we    = p_req && p_dest != 5'd0;
            e_drain = (q_rd.size() != 0) && !p_we;
            e_ready = (q_rd.size() == 0) || e_drain;
            e_we    = p_we || e_drain;
            e_addr  = p_we ? p_dest : (e_drain ? q_rd[0] : 5'd0);
            e_data  = p_we ? p_data : (e_drain ? q_data[0] : 32'd0);
            checks++;
            if ({rf_we, rf_waddr, rf_wdata} !== {e_we, e_addr, e_data})
                begin errors++; $display("FAIL rnd_rf[%0d] got %b/%0d/%h exp %b/%0d/%h",
                                         c, rf_we, rf_waddr, rf_wdata, e_we, e_addr, e_data); end
            checks++;
            if (md_ready !== e_ready)
                begin errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", c, md_ready, e_ready); end
            checks++;
            if (pend_valid !== (q_rd.size() != 0) || pend_rd !== ((q_rd.size() != 0) ? q_rd[0] : 5'd0))
                begin errors++; $display("FAIL rnd_pend[%0d] got %b/%0d exp %0d entries", c, pend_valid, pend_rd, q_rd.size()); end
            n_rd   = md_exception ? 5'd30 : md_rd;
            n_data = md_exception ? (md_is_div ? 32'd5 : 32'd4) : md_result;
            tick();
            if (e_drain) begin void'(q_rd.pop_front()); void'(q_data.pop_front()); end
            if (md_valid && e_ready && n_rd != 5'd0) begin q_rd.push_back(n_rd); q_data.push_back(n_data); end
        end
    endtask

    initial begin
        test_reset();
        test_pipeline();
        test_buffer_accept();
        test_back_to_back();
        test_exception();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the five-stage pipeline. It consumes the memory/writeback latch outputs, decides the register-file write (destination, data, overflow-status rewrite), and merges in results from the multi-cycle multiply/divide unit through a one-entry holding buffer. It drives the register-file write port and exposes a pending-write indication to the hazard unit.

## Interface
- No parameters; widths fixed at 32-bit data, 5-bit register address, 5-bit opcode.
- clock  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- mw_opcode  in  5  opcode from memory/writeback latch.
- mw_rd  in  5  destination from latch.
- mw_data  in  32  load data from latch.
- mw_alu  in  32  ALU result from latch.
- mw_target  in  32  link/target value from latch (jal return address, setx immediate).
- mw_overflow  in  1  ALU overflow flag from latch.
- md_valid  in  1  multdiv result offered.
- md_ready  out  1  buffer can accept; transfer occurs when md_valid && md_ready.
- md_result  in  32  multdiv result.
- md_rd  in  5  multdiv destination.
- md_exception  in  1  multdiv overflow or divide-by-zero.
- md_is_div  in  1  1 = divide, 0 = multiply (selects status code).
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- pend_valid  out  1  buffer holds an unwritten multdiv result.
- pend_rd  out  5  destination of buffered result (0 when empty).

## Operation
- Pipeline write request (combinational from latch):
  - 00000 (R-type ALU): dest = mw_rd, data = mw_alu; if mw_overflow, dest = 30, data = 1.
  - 00101 (addi): dest = mw_rd, data = mw_alu; if mw_overflow, dest = 30, data = 2.
  - 01000 (lw): dest = mw_rd, data = mw_data.
  - 00011 (jal): dest = 31, data = mw_target.
  - 10101 (setx): dest = 30, data = mw_target.
  - All other opcodes: no request.
- A request whose dest is 0 is dropped; it never asserts rf_we.
- Buffer: one entry {valid, rd, data}. On acceptance, data = md_exception ? (md_is_div ? 5 : 4) : md_result, and rd = md_exception ? 30 : md_rd.
- Arbitration: the pipeline request always wins, because the pipeline has no stall path. The buffer drains only in a cycle with no pipeline request.
- md_ready = !valid || drain_this_cycle. This allows a drain and a new accept in the same cycle.
- An accepted result with rd 0 and no exception is discarded at accept and never sets valid.
- Write port priority: pipeline request, then buffer, then idle (rf_we = 0; rf_waddr and rf_wdata = 0).

## Timing
- Pipeline path has zero latency: rf_we, rf_waddr and rf_wdata are combinational from the mw_* inputs in the same cycle.
- Buffer path: a result accepted at edge N is eligible to write in cycle N+1 at the earliest.
- Buffer states: EMPTY and FULL.
  - EMPTY to FULL on accept.
  - FULL to EMPTY on drain without accept.
  - FULL to FULL on drain with simultaneous accept (new contents), or on a blocked drain.
- Sustained pipeline requests starve the buffer. md_ready stays 0 while FULL and blocked.
- pend_valid and pend_rd are registered, and equal the buffer state.
- Reset (asynchronous, any cycle):
  - Buffer goes EMPTY; pend_valid = 0, pend_rd = 0, md_ready = 1.
  - A result held in the buffer is lost. The multdiv unit is reset in the same event.
- rf_* outputs during reset follow the mw_* inputs. The latch is itself reset to opcode 0 and rd 0, so rf_we = 0.

## Structure
- Shared package holds:
  - opcode constants (ALU 00000, ADDI 00101, LW 01000, JAL 00011, SETX 10101);
  - RSTATUS = 30, RA = 31;
  - status codes (ALU 1, ADDI 2, MULT 4, DIV 5).
- One sub-module, wb_decode: combinational opcode to {req, dest, data}. The buffer and arbitration live in the top.

## Test plan
- Latch opcode 00000, rd 5, alu 0x0000_0010, overflow 0 -> rf_we = 1, waddr 5, wdata 0x10 in the same cycle. Repeat with overflow 1 -> waddr 30, wdata 1.
- Opcode 00011, target 0x0000_0042 -> waddr 31, wdata 0x42. Opcode 00000 with rd 0 -> rf_we = 0.
- md_valid with md_rd 7, result 0x1234 while the pipeline is idle:
  - accepted with md_ready = 1;
  - the next cycle shows waddr 7, wdata 0x1234, then pend_valid drops.
- Buffer FULL (rd 7) with back-to-back lw requests for 3 cycles:
  - md_ready = 0 throughout and the lw writes win each cycle;
  - the buffer drains in the first idle cycle;
  - a second md_valid in that drain cycle is accepted.
- md_exception = 1 with md_is_div = 1 -> buffered write of waddr 30, wdata 5.
- Assert reset low mid-cycle while FULL -> pend_valid = 0 and md_ready = 1 immediately, before the next edge. After release, no stale write occurs.
